// File: rtl/water_level_matrix_scanner_if.sv
// Bus between the level-classification logic and the matrix scanner.
//
// Strobe semantics: there is no back-pressure. level is sampled on every
// rising clk edge where level_valid=1 (the scanner is always ready); the
// last strobe before a frame boundary is the one displayed. col_sel, row
// and frame_start are registered outputs that change together on the
// scanner's clock edge.
interface water_level_matrix_scanner_if #(
  parameter int COLS    = 5,
  parameter int ROWS    = 7,
  parameter int LEVEL_W = 2
);
  logic [LEVEL_W-1:0] level;
  logic               level_valid;
  logic [COLS-1:0]    col_sel;
  logic [ROWS-1:0]    row;
  logic               frame_start;

  // Level source side (classification logic or bench).
  modport master (
    output level, level_valid,
    input  col_sel, row, frame_start
  );

  // Scanner side.
  modport slave (
    input  level, level_valid,
    output col_sel, row, frame_start
  );
endinterface

// File: rtl/water_level_matrix_scanner.sv
// Column-multiplexed "tank" display for a COLS x ROWS LED matrix.
// Border columns are fully lit; interior columns are filled from the bottom
// in proportion to the displayed level. The level is captured into a shadow
// register on any strobe and copied to the display only at the start of a
// frame, so a frame never shows two different levels.
// Optional feature macro: WATER_LEVEL_BLINK_EN (blank the critical level on
// alternating groups of BLINK_FRAMES frames).
module water_level_matrix_scanner #(
  parameter int COLS         = 5,
  parameter int ROWS         = 7,
  parameter int LEVEL_W      = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  water_level_matrix_scanner_if.slave  bus
);

  localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TOP_LEVEL = (2 ** LEVEL_W) - 1;
  // Wide enough for level*(ROWS-1) and for a fill count of ROWS.
  localparam int PROD_W    = LEVEL_W + $clog2(ROWS) + 1;

  logic               running;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LEVEL_W-1:0] shadow_q;
  logic [LEVEL_W-1:0] disp_q, disp_d;
  logic               load;
  logic               blank_d;
  logic [COLS-1:0]    col_sel_d;
  logic [ROWS-1:0]    row_d;

  // Interior column pattern: the bottom F rows lit,
  // F = floor(level*(ROWS-1)/TOP_LEVEL) + 1.
  function automatic logic [ROWS-1:0] interior_rows(input logic [LEVEL_W-1:0] lvl);
    logic [PROD_W-1:0] fill;
    fill = ((PROD_W'(lvl) * PROD_W'(ROWS - 1)) / PROD_W'(TOP_LEVEL)) + PROD_W'(1);
    for (int r = 0; r < ROWS; r++) begin
      interior_rows[r] = (PROD_W'(r) < fill);
    end
  endfunction

  // Scan sequencing: divider, column index, frame boundary and display load.
  // The first edge out of reset starts a column-0 dwell directly.
  always_comb begin
    load   = 1'b0;
    div_d  = div_q;
    col_d  = col_q;
    disp_d = disp_q;
    if (!running) begin
      load  = 1'b1;
      div_d = '0;
      col_d = '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        load  = 1'b1;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    // The shadow is read before this edge's strobe lands, so a coincident
    // strobe only shows from the next frame.
    if (load) disp_d = shadow_q;
  end

`ifdef WATER_LEVEL_BLINK_EN
  localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;

  // Blink timing: count frames spent at level 0 and flip the phase once
  // BLINK_FRAMES of them have been shown; any non-zero level clears both.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (disp_d != '0) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (load) begin
      if (bcnt_q == BCNT_W'(BLINK_FRAMES)) begin
        bcnt_d  = BCNT_W'(1);
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank_d = phase_d;
`else
  // Static display: level 0 shows the borders plus the bottom row.
  // BLINK_FRAMES stays referenced so both builds share one parameter list.
  if (BLINK_FRAMES < 1) begin : g_blink_frames_unused
  end
  assign blank_d = 1'b0;
`endif

  // Next output image for the column that the coming edge selects.
  always_comb begin
    col_sel_d        = '0;
    col_sel_d[col_d] = 1'b1;
    row_d            = '0;
    if (!blank_d) begin
      if (col_d == '0 || col_d == COL_W'(COLS - 1)) row_d = '1;
      else                                          row_d = interior_rows(disp_d);
    end
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running         <= 1'b0;
      div_q           <= '0;
      col_q           <= '0;
      shadow_q        <= '0;
      disp_q          <= '0;
      bus.col_sel     <= '0;
      bus.row         <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      running         <= 1'b1;
      div_q           <= div_d;
      col_q           <= col_d;
      disp_q          <= disp_d;
      if (bus.level_valid) shadow_q <= bus.level;
      bus.col_sel     <= col_sel_d;
      bus.row         <= row_d;
      bus.frame_start <= load;
    end
  end

endmodule
